// File: rtl/sevenseg_pkg.sv
// Shared types, glyph constants and the nibble-to-segment decoder for the
// multiplexed seven-segment display driver.
package sevenseg_pkg;

  localparam int unsigned MAX_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * MAX_DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  // Active-high segments, bit 0 = a .. bit 6 = g
  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one add-3/shift step per clock, WIDTH
// steps after start_i. done_c flags the cycle performing the final step.
module bin2bcd_seq
  import sevenseg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] bin_i,
  output logic             done_c,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(MAX_DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_c = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d          = cnt_q + CNT_W'(1);
      if (done_c) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment driver: captures a binary value, converts it to
// decimal or hex digits and time-multiplexes them across DIGITS commons.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  input  logic              hex_mode,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] digit_en,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e                 state_q, state_d;
  logic                   req_q, accept, start, commit, conv_done;
  logic [WIDTH-1:0]       val_q;
  logic                   hex_q, blz_q;
  logic [BCD_W-1:0]       bcd, src;
  logic                   ovf_new, seen;
  logic [DIGITS-1:0]      blank_new, blank_q;
  logic [DIGITS-1:0][3:0] dig_q;
  logic                   ovf_q;
  logic [CNT_W-1:0]       refresh_q, refresh_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [6:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      en_q, en_d;
  logic                   busy_q;

  // A request is registered first; a second load is dropped until it drains
  assign accept = load && (state_q == ST_IDLE) && !req_q;

  bin2bcd_seq #(.WIDTH(WIDTH)) u_bin2bcd (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .bin_i  (val_q),
    .done_c (conv_done),
    .bcd_o  (bcd)
  );

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_q) begin
          state_d = hex_q ? ST_COMMIT : ST_CONVERT;
          start   = !hex_q;
        end
      end
      ST_CONVERT: if (conv_done) state_d = ST_COMMIT;
      ST_COMMIT: begin
        state_d = ST_IDLE;
        commit  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Digit source, overflow and leading-zero mask for the commit cycle
  always_comb begin
    src       = hex_q ? BCD_W'(val_q) : bcd;
    ovf_new   = 1'b0;
    seen      = 1'b0;
    blank_new = '0;
    for (int i = int'(DIGITS); i < int'(MAX_DIGITS); i++) begin
      if (src[4*i +: 4] != 4'd0) ovf_new = 1'b1;
    end
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      seen         = seen | (src[4*i +: 4] != 4'd0);
      blank_new[i] = blz_q & !seen & !ovf_new;
    end
  end

  always_comb begin
    refresh_d = refresh_q + CNT_W'(1);
    idx_d     = idx_q;
    if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      idx_d     = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    en_d        = '0;
    en_d[idx_q] = 1'b1;
    if (ovf_q)                seg_d = SEG_DASH;
    else if (blank_q[idx_q])  seg_d = SEG_BLANK;
    else                      seg_d = nibble_to_seg(dig_q[idx_q]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      val_q     <= '0;
      hex_q     <= 1'b0;
      blz_q     <= 1'b0;
      dig_q     <= '0;
      blank_q   <= '0;
      ovf_q     <= 1'b0;
      refresh_q <= '0;
      idx_q     <= '0;
      seg_q     <= '0;
      en_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= accept;
      if (accept) begin
        val_q <= value;
        hex_q <= hex_mode;
        blz_q <= blank_lz;
      end
      if (commit) begin
        dig_q   <= src[4*DIGITS-1:0];
        blank_q <= blank_new;
        ovf_q   <= ovf_new;
      end
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      en_q      <= en_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign seg      = seg_q;
  assign digit_en = en_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule
